engine_scheduler: RTL and testbench

Frame-level controller for the pixel-engine array. On a start request it walks every pixel of the screen in raster order and hands each coordinate to a free engine, using round-robin arbitration among the free engines. It tracks per-engine busy state from engine completion pulses and signals end of frame once the last engine has retired. It sits between the frame/host control logic and the NUM_ENGINES compute engines.

---
 rtl/engine_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_engine_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_scheduler.sv
// engine_scheduler: walks the screen in raster order and hands each pixel to a free engine (round-robin).
// Build option ENGINE_TIMEOUT_EN adds per-engine watchdogs that drop hung assignments and flag timeout_err.
module engine_scheduler #(
  parameter int DATA_WIDTH     = 32,
  parameter int SCREEN_WIDTH   = 640,
  parameter int SCREEN_HEIGHT  = 480,
  parameter int NUM_ENGINES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic                   pause,
  input  logic [NUM_ENGINES-1:0] done_bus,
  output logic [NUM_ENGINES-1:0] assign_bus,
  output logic [DATA_WIDTH-1:0]  xcoord,
  output logic [DATA_WIDTH-1:0]  ycoord,
  output logic [NUM_ENGINES-1:0] busy_mask,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic [DATA_WIDTH-1:0]  dispatch_count,
  output logic                   proto_err,
  output logic                   timeout_err
);
  localparam int PTR_W = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
  localparam logic [DATA_WIDTH-1:0] X_LAST = DATA_WIDTH'(SCREEN_WIDTH - 1);
  localparam logic [DATA_WIDTH-1:0] Y_LAST = DATA_WIDTH'(SCREEN_HEIGHT - 1);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [DATA_WIDTH-1:0]  x_q, x_d, y_q, y_d;
  logic [DATA_WIDTH-1:0]  xcoord_q, xcoord_d, ycoord_q, ycoord_d;
  logic [DATA_WIDTH-1:0]  dispatch_count_q, dispatch_count_d;
  logic [NUM_ENGINES-1:0] assign_bus_q, assign_bus_d, busy_mask_q, busy_mask_d;
  logic                   frame_busy_q, frame_busy_d, frame_done_q, frame_done_d;
  logic                   proto_err_q, proto_err_d, timeout_err_q, timeout_err_d;
  logic [NUM_ENGINES-1:0] expire;
  logic                   grant_vld, grant_take;
  logic [PTR_W-1:0]       grant_idx;

  // First free engine at or after rr_ptr, wrapping; uses last cycle's busy view.
  always_comb begin
    logic [PTR_W-1:0] idx;
    idx       = '0;
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NUM_ENGINES; k++) begin
      idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_ENGINES);
      if (!grant_vld && !busy_mask_q[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  assign grant_take = (state_q == S_DISPATCH) && !pause && grant_vld;

`ifdef ENGINE_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  logic [TMR_W-1:0] tmr_q [NUM_ENGINES];
  logic [TMR_W-1:0] tmr_d [NUM_ENGINES];

  always_comb begin
    expire = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      tmr_d[i]  = tmr_q[i];
      expire[i] = busy_mask_q[i] && !done_bus[i] && (tmr_q[i] == TMR_LAST);
      if (grant_take && (grant_idx == PTR_W'(i))) tmr_d[i] = '0;
      else if (busy_mask_q[i] && !expire[i])      tmr_d[i] = tmr_q[i] + TMR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_ENGINES; i++) tmr_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_ENGINES; i++) tmr_q[i] <= tmr_d[i];
    end
  end
`else
  assign expire = '0;
`endif

  always_comb begin
    state_d          = state_q;
    rr_ptr_d         = rr_ptr_q;
    x_d              = x_q;
    y_d              = y_q;
    xcoord_d         = xcoord_q;
    ycoord_d         = ycoord_q;
    dispatch_count_d = dispatch_count_q;
    assign_bus_d     = '0;
    frame_busy_d     = frame_busy_q;
    frame_done_d     = 1'b0;
    proto_err_d      = proto_err_q | (|(done_bus & ~busy_mask_q));
    timeout_err_d    = timeout_err_q | (|expire);
    busy_mask_d      = busy_mask_q & ~done_bus & ~expire;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d          = S_DISPATCH;
          x_d              = '0;
          y_d              = '0;
          dispatch_count_d = '0;
          frame_busy_d     = 1'b1;
        end
      end
      S_DISPATCH: begin
        if (grant_take) begin
          assign_bus_d[grant_idx] = 1'b1;
          busy_mask_d[grant_idx]  = 1'b1;
          xcoord_d                = x_q;
          ycoord_d                = y_q;
          rr_ptr_d = (grant_idx == PTR_W'(NUM_ENGINES - 1)) ? '0 : grant_idx + PTR_W'(1);
          dispatch_count_d = dispatch_count_q + DATA_WIDTH'(1);
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + DATA_WIDTH'(1);
            if (y_q == Y_LAST) state_d = S_DRAIN;
          end else begin
            x_d = x_q + DATA_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if (busy_mask_d == '0) state_d = S_DONE;
      end
      S_DONE: begin
        frame_done_d = 1'b1;
        frame_busy_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q          <= S_IDLE;
      rr_ptr_q         <= '0;
      x_q              <= '0;
      y_q              <= '0;
      xcoord_q         <= '0;
      ycoord_q         <= '0;
      dispatch_count_q <= '0;
      assign_bus_q     <= '0;
      busy_mask_q      <= '0;
      frame_busy_q     <= 1'b0;
      frame_done_q     <= 1'b0;
      proto_err_q      <= 1'b0;
      timeout_err_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      rr_ptr_q         <= rr_ptr_d;
      x_q              <= x_d;
      y_q              <= y_d;
      xcoord_q         <= xcoord_d;
      ycoord_q         <= ycoord_d;
      dispatch_count_q <= dispatch_count_d;
      assign_bus_q     <= assign_bus_d;
      busy_mask_q      <= busy_mask_d;
      frame_busy_q     <= frame_busy_d;
      frame_done_q     <= frame_done_d;
      proto_err_q      <= proto_err_d;
      timeout_err_q    <= timeout_err_d;
    end
  end

  assign assign_bus     = assign_bus_q;
  assign xcoord         = xcoord_q;
  assign ycoord         = ycoord_q;
  assign busy_mask      = busy_mask_q;
  assign frame_busy     = frame_busy_q;
  assign frame_done     = frame_done_q;
  assign dispatch_count = dispatch_count_q;
  assign proto_err      = proto_err_q;
  assign timeout_err    = timeout_err_q;
endmodule

// File: tb/tb_engine_scheduler.sv
// Self-checking bench for engine_scheduler (4x2 screen, 2 engines) against a frame-level reference model.
module tb_engine_scheduler;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int N  = 2;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic reset_n, start, pause;
  logic [N-1:0]  done_bus, assign_bus, busy_mask;
  logic [DW-1:0] xcoord, ycoord, dispatch_count;
  logic frame_busy, frame_done, proto_err, timeout_err;

  int vectors = 0;
  int miscompares = 0;

  engine_scheduler #(
    .DATA_WIDTH(DW), .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H),
    .NUM_ENGINES(N), .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pause(pause), .done_bus(done_bus),
    .assign_bus(assign_bus), .xcoord(xcoord), .ycoord(ycoord), .busy_mask(busy_mask),
    .frame_busy(frame_busy), .frame_done(frame_done), .dispatch_count(dispatch_count),
    .proto_err(proto_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: frame phase, next raster index, engine occupancy and rotation pointer.
  typedef enum int {PH_IDLE, PH_DISP, PH_DRAIN, PH_DONE} phase_t;
  phase_t        m_ph;
  int            m_pix, m_rr;
  logic [N-1:0]  m_busy, e_assign;
  logic [DW-1:0] e_x, e_y, e_count;
  logic          e_fbusy, e_fdone, e_proto;
  int            cd [N];
  int            lat_mode [N];

  logic [103:0] obs, expv;
  assign obs = {assign_bus, xcoord, ycoord, busy_mask, frame_busy, frame_done,
                dispatch_count, proto_err, timeout_err};
  always_comb expv = {e_assign, e_x, e_y, m_busy, e_fbusy, e_fdone, e_count, e_proto, 1'b0};

  task automatic model_reset();
    m_ph = PH_IDLE; m_pix = 0; m_rr = 0; m_busy = '0; e_assign = '0;
    e_x = '0; e_y = '0; e_count = '0; e_fbusy = 1'b0; e_fdone = 1'b0; e_proto = 1'b0;
    for (int i = 0; i < N; i++) cd[i] = 0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; done_bus = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // One clock: engines raise due done pulses, model predicts, DUT clocks, engines see strobes.
  task automatic cycle(input logic st, input logic ps, input logic [N-1:0] xd);
    logic [N-1:0] dn, nb;
    int g;
    dn = xd;
    for (int i = 0; i < N; i++) begin
      if (cd[i] == 1) begin dn[i] = 1'b1; cd[i] = 0; end
      else if (cd[i] > 1) cd[i] = cd[i] - 1;
    end
    start = st; pause = ps; done_bus = dn;
    e_assign = '0; e_fdone = 1'b0; g = -1;
    nb = m_busy & ~dn;
    if (|(dn & ~m_busy)) e_proto = 1'b1;
    case (m_ph)
      PH_IDLE: if (st) begin m_ph = PH_DISP; m_pix = 0; e_count = '0; e_fbusy = 1'b1; end
      PH_DISP: begin
        if (!ps)
          for (int k = 0; k < N; k++)
            if (g < 0 && !m_busy[(m_rr + k) % N]) g = (m_rr + k) % N;
        if (g >= 0) begin
          e_assign[g] = 1'b1; nb[g] = 1'b1;
          e_x = DW'(m_pix % W); e_y = DW'(m_pix / W);
          m_pix++; e_count = e_count + 1; m_rr = (g + 1) % N;
          if (m_pix == W * H) m_ph = PH_DRAIN;
        end
      end
      PH_DRAIN: if (nb == '0) m_ph = PH_DONE;
      PH_DONE: begin e_fdone = 1'b1; e_fbusy = 1'b0; m_ph = PH_IDLE; end
      default: m_ph = PH_IDLE;
    endcase
    m_busy = nb;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (assign_bus[i]) begin
        if (lat_mode[i] > 0)      cd[i] = lat_mode[i];
        else if (lat_mode[i] < 0) cd[i] = int'($urandom_range(1, 5));
        else                      cd[i] = 0;
      end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL reset_state: got %h expected %h", obs, expv); end
    lat_mode = '{3, 3};
    cycle(1'b1, 1'b0, '0);
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL pre_reset_run: got %h expected %h", obs, expv); end
    end
    #1 reset_n = 1'b0;
    #2;
    vectors++;
    if (obs !== '0) begin miscompares++; $display("FAIL async_reset: got %h expected 0", obs); end
    model_reset(); done_bus = '0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    cycle(1'b1, 1'b0, '0);
    vectors++;
    if (assign_bus !== 2'b00 || frame_busy !== 1'b1) begin
      miscompares++; $display("FAIL start_edge: assign=%b frame_busy=%b expected 00/1", assign_bus, frame_busy);
    end
    cycle(1'b0, 1'b0, '0);
    vectors++;
    if ({assign_bus, xcoord, ycoord} !== {2'b01, 32'd0, 32'd0}) begin
      miscompares++; $display("FAIL first_strobe: assign=%b x=%0d y=%0d expected 01 (0,0)", assign_bus, xcoord, ycoord);
    end
    vectors++;
    if (obs !== expv) begin miscompares++; $display("FAIL first_strobe_model: got %h expected %h", obs, expv); end
  endtask

  task automatic test_full_frame();
    int strobes, fdones, zero_cyc, done_cyc;
    logic prev_nz;
    logic [N-1:0] oh;
    do_reset();
    lat_mode = '{3, 3};
    strobes = 0; fdones = 0; zero_cyc = -10; done_cyc = -1; prev_nz = 1'b0;
    cycle(1'b1, 1'b0, '0);
    for (int c = 0; c < 40; c++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL full_frame c=%0d: got %h expected %h", c, obs, expv); end
      if (assign_bus != '0) begin
        oh = N'(1) << (strobes % 2);
        vectors++;
        if (assign_bus !== oh || xcoord !== DW'(strobes % W) || ycoord !== DW'(strobes / W)) begin
          miscompares++;
          $display("FAIL frame_order n=%0d: assign=%b (%0d,%0d) expected %b (%0d,%0d)",
                   strobes, assign_bus, xcoord, ycoord, oh, strobes % W, strobes / W);
        end
        strobes++;
      end
      if (frame_done) begin fdones++; done_cyc = c; end
      if (busy_mask == '0 && prev_nz) zero_cyc = c;
      prev_nz = (busy_mask != '0);
    end
    vectors++;
    if (strobes != 8 || fdones != 1 || done_cyc != zero_cyc + 1 || dispatch_count !== 32'd8) begin
      miscompares++;
      $display("FAIL frame_summary: strobes=%0d done_pulses=%0d count=%0d gap=%0d expected 8/1/8/1",
               strobes, fdones, dispatch_count, done_cyc - zero_cyc);
    end
  endtask

  task automatic test_pause();
    int strobes;
    logic seen, fin;
    do_reset();
    lat_mode = '{2, 2};
    strobes = 0;
    cycle(1'b1, 1'b0, '0);
    for (int c = 0; c < 30 && strobes < 3; c++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL pause_pre: got %h expected %h", obs, expv); end
      if (assign_bus != '0) strobes++;
    end
    vectors++;
    if (strobes != 3) begin miscompares++; $display("FAIL pause_setup: strobes=%0d expected 3", strobes); end
    for (int c = 0; c < 5; c++) begin
      cycle(1'b0, 1'b1, '0);
      vectors++;
      if (assign_bus !== '0 || obs !== expv) begin
        miscompares++; $display("FAIL pause_hold c=%0d: got %h expected %h", c, obs, expv);
      end
    end
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL pause_release: got %h expected %h", obs, expv); end
      if (assign_bus != '0) begin
        seen = 1'b1;
        vectors++;
        if (xcoord !== 32'd3 || ycoord !== 32'd0) begin
          miscompares++; $display("FAIL pause_resume_coord: (%0d,%0d) expected (3,0)", xcoord, ycoord);
        end
      end
    end
    vectors++;
    if (!seen) begin miscompares++; $display("FAIL pause_resume: no strobe expected one"); end
    fin = 1'b0;
    for (int c = 0; c < 60 && !fin; c++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL pause_tail: got %h expected %h", obs, expv); end
      if (frame_done) fin = 1'b1;
    end
    vectors++;
    if (!fin) begin miscompares++; $display("FAIL pause_frame_done: none expected one"); end
  endtask

  task automatic test_hung();
    int fdones;
    logic hung;
    do_reset();
    lat_mode = '{3, 0};
    fdones = 0; hung = 1'b0;
    cycle(1'b1, 1'b0, '0);
    for (int c = 0; c < 60; c++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (obs !== expv) begin miscompares++; $display("FAIL hung c=%0d: got %h expected %h", c, obs, expv); end
      if (assign_bus[1]) begin
        if (hung) begin miscompares++; $display("FAIL hung_regrant: engine 1 granted twice expected once"); end
        hung = 1'b1;
      end
      if (frame_done) fdones++;
    end
    vectors++;
    if (busy_mask !== 2'b10 || fdones != 0 || frame_busy !== 1'b1 || dispatch_count !== 32'd8) begin
      miscompares++;
      $display("FAIL hung_drain: busy=%b done_pulses=%0d frame_busy=%b count=%0d expected 10/0/1/8",
               busy_mask, fdones, frame_busy, dispatch_count);
    end
  endtask

  task automatic test_proto();
    do_reset();
    lat_mode = '{3, 3};
    cycle(1'b0, 1'b0, 2'b01);
    vectors++;
    if (proto_err !== 1'b1 || busy_mask !== 2'b00 || frame_busy !== 1'b0) begin
      miscompares++; $display("FAIL proto_set: err=%b busy=%b fb=%b expected 1/00/0", proto_err, busy_mask, frame_busy);
    end
    for (int c = 0; c < 3; c++) begin
      cycle(1'b0, 1'b0, '0);
      vectors++;
      if (proto_err !== 1'b1 || obs !== expv) begin
        miscompares++; $display("FAIL proto_sticky: got %h expected %h", obs, expv);
      end
    end
  endtask

  task automatic test_back_to_back();
    int fdones;
    logic st, ps;
    do_reset();
    lat_mode = '{-1, -1};
    fdones = 0;
    for (int f = 0; f < 3; f++) begin
      cycle(1'b1, ($urandom % 4) == 0, '0);
      for (int c = 0; c < 200 && m_ph != PH_IDLE; c++) begin
        st = (m_ph == PH_DISP || m_ph == PH_DRAIN) && (($urandom % 8) == 0);
        ps = ($urandom % 4) == 0;
        cycle(st, ps, '0);
        vectors++;
        if (obs !== expv) begin miscompares++; $display("FAIL b2b f=%0d c=%0d: got %h expected %h", f, c, obs, expv); end
        if (frame_done) fdones++;
      end
      vectors++;
      if (dispatch_count !== 32'd8) begin
        miscompares++; $display("FAIL b2b_count f=%0d: got %0d expected 8", f, dispatch_count);
      end
    end
    vectors++;
    if (fdones != 3) begin miscompares++; $display("FAIL b2b_frames: got %0d expected 3", fdones); end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; pause = 1'b0; done_bus = '0;
    for (int i = 0; i < N; i++) lat_mode[i] = 3;
    model_reset();
    test_reset();
    test_full_frame();
    test_pause();
    test_proto();
    test_back_to_back();
    test_hung();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end
endmodule
